// File: rtl/cache_arbiter_if.sv
// Bundle of I-cache, D-cache and memory-port signals around the cache arbiter.
// slave is the arbiter's view; master is the caches/memory side.
interface cache_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned LINE_W = 256
);
   logic              i_read;
   logic [ADDR_W-1:0] i_addr;
   logic [LINE_W-1:0] i_rdata;
   logic              i_resp;
   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [LINE_W-1:0] d_wdata;
   logic [LINE_W-1:0] d_rdata;
   logic              d_resp;
   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_addr;
   logic [LINE_W-1:0] pmem_wdata;
   logic [LINE_W-1:0] pmem_rdata;
   logic              pmem_resp;

   modport slave (
      input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
      output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
   );

   modport master (
      output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
      input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
   );
endinterface

// File: rtl/cache_arbiter.sv
// Non-preemptive arbiter sharing one memory port between I- and D-cache fills.
// D has priority, bounded by a starvation counter that eventually forces an I grant.
module cache_arbiter #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned LINE_W     = 256,
   parameter int unsigned STARVE_MAX = 4
) (
   input logic            clk,
   input logic            rst,
   cache_arbiter_if.slave bus
);
   localparam int unsigned      CNT_W   = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GNT_I = 2'd1;
   localparam logic [1:0] GNT_D = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic              wr_q,    wr_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic              d_pend;

   assign d_pend = bus.d_read | bus.d_write;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wr_d    = wr_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (d_pend && (!bus.i_read || (cnt_q < CNT_MAX))) begin
               state_d = GNT_D;
               addr_d  = bus.d_addr;
               wdata_d = bus.d_wdata;
               // write wins when both read and write are requested
               wr_d    = bus.d_write;
               if (!bus.i_read)
                  cnt_d = '0;
               else if (cnt_q != CNT_MAX)
                  cnt_d = cnt_q + 1'b1;
            end else if (bus.i_read) begin
               state_d = GNT_I;
               addr_d  = bus.i_addr;
               wr_d    = 1'b0;
               cnt_d   = '0;
            end else begin
               cnt_d = '0;
            end
         end
         GNT_I, GNT_D: begin
            if (bus.pmem_resp)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Memory port is driven only from the latched request for the whole grant.
   assign bus.pmem_read  = (state_q == GNT_I) || ((state_q == GNT_D) && !wr_q);
   assign bus.pmem_write = (state_q == GNT_D) && wr_q;
   assign bus.pmem_addr  = addr_q;
   assign bus.pmem_wdata = wdata_q;

   assign bus.i_resp  = (state_q == GNT_I) && bus.pmem_resp;
   assign bus.d_resp  = (state_q == GNT_D) && bus.pmem_resp;
   assign bus.i_rdata = bus.pmem_rdata;
   assign bus.d_rdata = bus.pmem_rdata;
endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed vector table, hand-written
// starvation and reset sequences, then random traffic against a transaction model.
module tb_cache_arbiter;
   localparam int unsigned ADDR_W     = 32;
   localparam int unsigned LINE_W     = 256;
   localparam int unsigned STARVE_MAX = 4;
   localparam int unsigned NVEC       = 21;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   cache_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

   cache_arbiter #(
      .ADDR_W(ADDR_W),
      .LINE_W(LINE_W),
      .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic        ir, dr, dw;
      logic [31:0] ia, da, wd;
      logic        presp;
      logic        e_pr, e_pw;
      logic [31:0] e_addr, e_wd;
      logic        e_ir, e_dr;
   } vec_t;

   vec_t tbl [NVEC];

   function automatic vec_t mk(input logic ir, dr, dw, input logic [31:0] ia, da, wd,
                               input logic presp, e_pr, e_pw, input logic [31:0] e_addr, e_wd,
                               input logic e_ir, e_dr);
      vec_t v;
      v.ir = ir; v.dr = dr; v.dw = dw; v.ia = ia; v.da = da; v.wd = wd; v.presp = presp;
      v.e_pr = e_pr; v.e_pw = e_pw; v.e_addr = e_addr; v.e_wd = e_wd; v.e_ir = e_ir; v.e_dr = e_dr;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [3:0] outs();
      return {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp};
   endfunction

   task automatic clear_inputs();
      bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
      bus.i_addr = '0; bus.d_addr = '0; bus.d_wdata = '0;
      bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;
   endtask

   // Leaves the caller just after a falling edge with the DUT in reset state.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      clear_inputs();
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Transaction-level reference: who owns the port, what it asked for,
   // and how many D grants in a row have been given while I was waiting.
   int                m_owner;   // 0 none, 1 I-cache, 2 D-cache
   logic [ADDR_W-1:0] m_addr;
   logic [LINE_W-1:0] m_wd;
   logic              m_wr;
   int                m_passed;

   task automatic model_step(input logic r, ir, dr, dw, presp,
                             input logic [ADDR_W-1:0] ia, da, input logic [LINE_W-1:0] wd);
      if (r) begin
         m_owner = 0; m_passed = 0; m_addr = '0; m_wd = '0; m_wr = 1'b0;
      end else if (m_owner != 0) begin
         if (presp) m_owner = 0;
      end else if ((dr || dw) && !(ir && m_passed >= int'(STARVE_MAX))) begin
         m_owner = 2; m_addr = da; m_wd = wd; m_wr = dw;
         m_passed = ir ? ((m_passed + 1 > int'(STARVE_MAX)) ? int'(STARVE_MAX) : m_passed + 1) : 0;
      end else if (ir) begin
         m_owner = 1; m_addr = ia; m_wr = 1'b0; m_passed = 0;
      end else begin
         m_passed = 0;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [LINE_W-1:0] a5;
      logic [9:0]        order;
      int                grants;
      logic              e_pr, e_pw;

      a5 = {(LINE_W/8){8'hA5}};
      //        ir dr dw ia            da            wd            rsp  pr pw addr          wd            ir dr
      tbl[0]  = mk(1, 0, 0, 32'h0000_1000, 32'h0,        32'h0,        0,   0, 0, 32'h0,        32'h0,        0, 0);
      tbl[1]  = mk(0, 0, 0, 32'h0000_1000, 32'h0,        32'h0,        0,   1, 0, 32'h0000_1000, 32'h0,       0, 0);
      tbl[2]  = tbl[1];
      tbl[3]  = tbl[1];
      tbl[4]  = tbl[1];
      tbl[5]  = mk(0, 0, 0, 32'h0000_1000, 32'h0,        32'h0,        1,   1, 0, 32'h0000_1000, 32'h0,       1, 0);
      tbl[6]  = mk(1, 0, 1, 32'h0000_1040, 32'h0000_2000, 32'h1234_5678, 0,  0, 0, 32'h0,        32'h0,        0, 0);
      tbl[7]  = mk(1, 0, 0, 32'h0000_1040, 32'h0000_2000, 32'h1234_5678, 0,  0, 1, 32'h0000_2000, 32'h1234_5678, 0, 0);
      tbl[8]  = mk(1, 0, 0, 32'h0000_1040, 32'h0000_2000, 32'h0,        1,   0, 1, 32'h0000_2000, 32'h1234_5678, 0, 1);
      tbl[9]  = mk(1, 0, 0, 32'h0000_1040, 32'h0,        32'h0,        0,   0, 0, 32'h0,        32'h0,        0, 0);
      tbl[10] = mk(0, 0, 0, 32'h0000_1040, 32'h0,        32'h0,        1,   1, 0, 32'h0000_1040, 32'h0,       1, 0);
      tbl[11] = mk(0, 0, 0, 32'h0,        32'h0,        32'h0,        1,   0, 0, 32'h0,        32'h0,        0, 0);
      tbl[12] = mk(0, 1, 1, 32'h0,        32'h0000_3000, 32'hDEAD_BEEF, 0,  0, 0, 32'h0,        32'h0,        0, 0);
      tbl[13] = mk(0, 1, 0, 32'h0,        32'h0000_4000, 32'h0,        0,   0, 1, 32'h0000_3000, 32'hDEAD_BEEF, 0, 0);
      tbl[14] = mk(0, 0, 0, 32'h0,        32'h0000_4000, 32'h0,        1,   0, 1, 32'h0000_3000, 32'hDEAD_BEEF, 0, 1);
      tbl[15] = mk(0, 0, 0, 32'h0,        32'h0,        32'h0,        0,   0, 0, 32'h0,        32'h0,        0, 0);
      tbl[16] = mk(0, 1, 0, 32'h0,        32'h0000_2000, 32'h0,        0,   0, 0, 32'h0,        32'h0,        0, 0);
      tbl[17] = mk(0, 0, 0, 32'h0,        32'h0000_3000, 32'h0,        0,   1, 0, 32'h0000_2000, 32'h0,       0, 0);
      tbl[18] = tbl[17];
      tbl[19] = mk(0, 0, 0, 32'h0,        32'h0000_3000, 32'h0,        1,   1, 0, 32'h0000_2000, 32'h0,       0, 1);
      tbl[20] = tbl[15];

      clear_inputs();
      do_reset();
      #1 chk("reset_outputs", LINE_W'(outs()), '0);

      for (int k = 0; k < int'(NVEC); k++) begin
         bus.i_read  = tbl[k].ir;  bus.d_read = tbl[k].dr;  bus.d_write = tbl[k].dw;
         bus.i_addr  = tbl[k].ia;  bus.d_addr = tbl[k].da;
         bus.d_wdata = {(LINE_W/32){tbl[k].wd}};
         bus.pmem_resp  = tbl[k].presp;
         bus.pmem_rdata = (k == 5) ? a5 : (a5 ^ LINE_W'(k));
         #1;
         chk($sformatf("vec%0d_strobes_resps", k), LINE_W'(outs()),
             LINE_W'({tbl[k].e_pr, tbl[k].e_pw, tbl[k].e_ir, tbl[k].e_dr}));
         if (tbl[k].e_pr || tbl[k].e_pw)
            chk($sformatf("vec%0d_pmem_addr", k), LINE_W'(bus.pmem_addr), LINE_W'(tbl[k].e_addr));
         if (tbl[k].e_pw)
            chk($sformatf("vec%0d_pmem_wdata", k), bus.pmem_wdata, {(LINE_W/32){tbl[k].e_wd}});
         if (k == 5) chk("lone_fill_i_rdata", bus.i_rdata, a5);
         else if (k % 4 == 0) begin
            chk($sformatf("vec%0d_i_rdata", k), bus.i_rdata, a5 ^ LINE_W'(k));
            chk($sformatf("vec%0d_d_rdata", k), bus.d_rdata, a5 ^ LINE_W'(k));
         end
         @(negedge clk);
      end

      // Starvation: I and D both held high, memory answers every grant at once.
      do_reset();
      bus.i_read = 1'b1; bus.d_read = 1'b1;
      bus.i_addr = 32'h0000_0100; bus.d_addr = 32'h0000_0200;
      bus.pmem_resp = 1'b1;
      grants = 0;
      order  = '0;
      for (int cyc = 0; cyc < 40 && grants < 10; cyc++) begin
         #1;
         if (bus.pmem_read || bus.pmem_write) begin
            order[grants] = (bus.pmem_addr == 32'h0000_0100);
            grants++;
         end
         @(negedge clk);
      end
      chk("starve_grant_count", LINE_W'(grants), LINE_W'(10));
      for (int g = 0; g < 10; g++)
         chk($sformatf("starve_grant%0d_is_i", g), LINE_W'(order[g]), LINE_W'((g == 4) || (g == 9)));

      // Reset while I owns the port, then a stale completion.
      do_reset();
      bus.i_read = 1'b1; bus.i_addr = 32'h0000_0500;
      @(negedge clk);
      bus.i_read = 1'b0;
      #1 chk("rst_mid_grant_before", LINE_W'(outs()), LINE_W'(4'b1000));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.pmem_resp = 1'b1;
      #1 chk("rst_mid_grant_stale_resp", LINE_W'(outs()), '0);
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      #1 chk("rst_mid_grant_idle", LINE_W'(outs()), '0);

      // Random traffic against the transaction model.
      do_reset();
      model_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      for (int c = 0; c < 3000; c++) begin
         rst            = ($urandom_range(0, 63) == 0);
         bus.i_read     = $urandom_range(0, 1) == 1;
         bus.d_read     = $urandom_range(0, 2) == 0;
         bus.d_write    = $urandom_range(0, 2) == 0;
         bus.i_addr     = $urandom;
         bus.d_addr     = $urandom;
         for (int w = 0; w < int'(LINE_W / 32); w++) begin
            bus.d_wdata[w*32 +: 32]    = $urandom;
            bus.pmem_rdata[w*32 +: 32] = $urandom;
         end
         bus.pmem_resp = $urandom_range(0, 9) < 3;
         #1;
         e_pr = (m_owner == 1) || (m_owner == 2 && !m_wr);
         e_pw = (m_owner == 2) && m_wr;
         chk("rand_strobes_resps", LINE_W'(outs()),
             LINE_W'({e_pr, e_pw, (m_owner == 1) && bus.pmem_resp, (m_owner == 2) && bus.pmem_resp}));
         if (e_pr || e_pw) chk("rand_pmem_addr", LINE_W'(bus.pmem_addr), LINE_W'(m_addr));
         if (e_pw)         chk("rand_pmem_wdata", bus.pmem_wdata, m_wd);
         if (c % 16 == 0) begin
            chk("rand_i_rdata", bus.i_rdata, bus.pmem_rdata);
            chk("rand_d_rdata", bus.d_rdata, bus.pmem_rdata);
         end
         model_step(rst, bus.i_read, bus.d_read, bus.d_write, bus.pmem_resp,
                    bus.i_addr, bus.d_addr, bus.d_wdata);
         @(negedge clk);
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
